audio_fft_framer: RTL and testbench

//  Sits between the microphone front end and the 512-point FFT core, on the 98.304 MHz audio clock.
//  - Buffers 16-bit signed mic samples in a small FIFO and packs them as AXI-Stream FFT input words.
//  - Asserts tlast on exactly every FRAME_LEN-th word, so frame alignment survives FFT backpressure.
//  - Gates framing with enable_in; optional pre-emphasis filter.

---
 rtl/audio_fft_framer.sv | 228 ++++++++++++++++++++++
 tb/tb_audio_fft_framer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_fft_framer.sv
// audio_fft_framer: buffers 16-bit mic samples and packs them as AXI-Stream FFT input
// words, with tlast on every FRAME_LEN-th word. Dropped samples become zero words, so
// output frames keep their length.
// Optional pre-emphasis input filter: define AUDIO_FFT_FRAMER_PREEMPH_EN.
module audio_fft_framer #(
  parameter int unsigned FRAME_LEN     = 512,
  parameter int unsigned FIFO_DEPTH    = 16
`ifdef AUDIO_FFT_FRAMER_PREEMPH_EN
  ,
  parameter int unsigned PREEMPH_SHIFT = 5
`endif
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] audio_data_in,
  input  logic        audio_valid_in,
  input  logic        enable_in,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        overflow_out,
  output logic [15:0] drop_count_out,
  output logic [15:0] frame_count_out
);

  localparam int unsigned CNT_W  = $clog2(FRAME_LEN);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned PEND_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic [CNT_W-1:0]   r_in_cnt;

  logic               r_stg_valid;
  logic [15:0]        r_stg_data;
  logic [15:0]        w_stg_din;

  logic [15:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [OCC_W-1:0]   r_occ;
  logic [PEND_W-1:0]  r_pend;
  logic [CNT_W-1:0]   r_wcnt;

  logic [15:0]        r_tdata16;
  logic               r_tvalid;
  logic               r_tlast;
  logic               r_overflow;
  logic [15:0]        r_drop_cnt;
  logic [15:0]        r_frame_cnt;

  logic               w_rd;
  logic               w_space;
  logic               w_zero_wr;
  logic               w_stg_wr;
  logic               w_wr;
  logic [15:0]        w_wr_data;
  logic               w_drop;
  logic [PEND_W-1:0]  w_pend_nxt;
  logic [OCC_W-1:0]   w_occ_nxt;
  logic [OCC_W-1:0]   w_left;
  logic [PTR_W-1:0]   w_rd_ptr_nxt;
  logic [CNT_W-1:0]   w_wcnt_nxt;
  logic [15:0]        w_head_nxt;

`ifdef AUDIO_FFT_FRAMER_PREEMPH_EN
  logic signed [15:0] r_x_prev;
  logic signed [17:0] w_pe_sum;

  // Previous raw sample, tracked on every strobe regardless of framing state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_x_prev <= '0;
    end else if (audio_valid_in) begin
      r_x_prev <= $signed(audio_data_in);
    end
  end

  // Pre-emphasis y = x - x_prev + (x_prev >>> shift), saturated to 16 bits.
  always_comb begin
    w_pe_sum = 18'($signed(audio_data_in)) - 18'(r_x_prev) + 18'(r_x_prev >>> PREEMPH_SHIFT);
    if (w_pe_sum > 18'sd32767) begin
      w_stg_din = 16'h7FFF;
    end else if (w_pe_sum < -18'sd32768) begin
      w_stg_din = 16'h8000;
    end else begin
      w_stg_din = w_pe_sum[15:0];
    end
  end
`else
  assign w_stg_din = audio_data_in;
`endif

  // Framing FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Framing FSM: decides which strobes belong to a frame and when framing stops.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (audio_valid_in && enable_in) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (audio_valid_in) begin
          w_accept = 1'b1;
          if ((r_in_cnt == CNT_W'(FRAME_LEN - 1)) && !enable_in) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((r_occ == '0) && !r_stg_valid && (r_pend == '0)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FIFO write arbitration: pending zero words go ahead of the stage sample, which is
  // always the newest word. On overflow the stalled stage sample is the one discarded
  // and its slot becomes a zero word, so word order is preserved with one counter.
  always_comb begin
    w_rd      = r_tvalid && m_axis_tready;
    w_space   = (r_occ != OCC_W'(FIFO_DEPTH)) || w_rd;
    w_zero_wr = (r_pend != '0) && w_space;
    w_stg_wr  = r_stg_valid && (r_pend == '0) && w_space;
    w_wr      = w_zero_wr || w_stg_wr;
    w_wr_data = w_zero_wr ? 16'h0000 : r_stg_data;
    w_drop    = w_accept && r_stg_valid && !w_stg_wr;

    w_pend_nxt = r_pend;
    if (w_zero_wr && !w_drop) begin
      w_pend_nxt = r_pend - PEND_W'(1);
    end else if (w_drop && !w_zero_wr && (r_pend != '1)) begin
      w_pend_nxt = r_pend + PEND_W'(1);
    end

    w_occ_nxt    = r_occ + OCC_W'(w_wr) - OCC_W'(w_rd);
    w_left       = r_occ - OCC_W'(w_rd);
    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_rd);
    w_wcnt_nxt   = r_wcnt + CNT_W'(w_rd);
    w_head_nxt   = (w_left == '0) ? w_wr_data : r_mem[w_rd_ptr_nxt];
  end

  // Sample storage (flop array, no reset needed on contents).
  always_ff @(posedge clk_in) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  // Stage, FIFO bookkeeping, registered AXI outputs and status counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_in_cnt    <= '0;
      r_stg_valid <= 1'b0;
      r_stg_data  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_pend      <= '0;
      r_wcnt      <= '0;
      r_tdata16   <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_in_cnt    <= r_in_cnt + CNT_W'(1);
        r_stg_valid <= 1'b1;
        r_stg_data  <= w_stg_din;
      end else if (w_stg_wr) begin
        r_stg_valid <= 1'b0;
      end
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_occ     <= w_occ_nxt;
      r_pend    <= w_pend_nxt;
      r_wcnt    <= w_wcnt_nxt;
      // Output register always mirrors the FIFO head, so it holds while stalled.
      r_tdata16 <= (w_occ_nxt != '0) ? w_head_nxt : 16'h0000;
      r_tvalid  <= (w_occ_nxt != '0);
      r_tlast   <= (w_occ_nxt != '0) && (w_wcnt_nxt == CNT_W'(FRAME_LEN - 1));
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
      if (w_rd && r_tlast) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign m_axis_tdata    = {r_tdata16, 16'h0000};
  assign m_axis_tvalid   = r_tvalid;
  assign m_axis_tlast    = r_tlast;
  assign overflow_out    = r_overflow;
  assign drop_count_out  = r_drop_cnt;
  assign frame_count_out = r_frame_cnt;

endmodule

// File: tb/tb_audio_fft_framer.sv
// Testbench for audio_fft_framer: randomized streams, a reference model of the
// framing rules feeding an expected-word queue, and an independent output monitor.
`timescale 1ns/1ps
module tb_audio_fft_framer;

  localparam int unsigned FRAME_LEN  = 512;
  localparam int unsigned FIFO_DEPTH = 16;
`ifdef AUDIO_FFT_FRAMER_PREEMPH_EN
  localparam int unsigned PREEMPH_SHIFT = 5;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [15:0] audio_data_in = '0;
  logic        audio_valid_in = 1'b0;
  logic        enable_in = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic        overflow_out;
  logic [15:0] drop_count_out;
  logic [15:0] frame_count_out;

  audio_fft_framer #(
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .audio_data_in   (audio_data_in),
    .audio_valid_in  (audio_valid_in),
    .enable_in       (enable_in),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .overflow_out    (overflow_out),
    .drop_count_out  (drop_count_out),
    .frame_count_out (frame_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          words_seen = 0;
  int          out_idx = 0;
  int          rdy_mode = 0;   // 0 low, 1 high, 2 toggle, 3 random (75% high)
  bit          m_active = 0;
  int          m_in_cnt = 0;
  logic [15:0] last_y;
`ifdef AUDIO_FFT_FRAMER_PREEMPH_EN
  int          m_xprev = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference transform of one raw sample into the word value it should produce.
  function automatic logic [15:0] model_y(input logic [15:0] x);
`ifdef AUDIO_FFT_FRAMER_PREEMPH_EN
    int d;
    d = int'($signed(x)) - m_xprev + (m_xprev >>> PREEMPH_SHIFT);
    if (d > 32767) d = 32767;
    else if (d < -32768) d = -32768;
    return 16'(d);
`else
    return x;
`endif
  endfunction

  // Queue one expected output word; tlast falls on every FRAME_LEN-th word.
  task automatic push_word(input logic [15:0] d);
    exp_t e;
    e.data = d;
    e.last = (out_idx == FRAME_LEN - 1);
    exp_q.push_back(e);
    out_idx = (out_idx + 1) % FRAME_LEN;
  endtask

  // Present one sample strobe; the model decides whether it belongs to a frame.
  task automatic strobe(input logic [15:0] x, input bit do_push, input int gap);
    logic [15:0] y;
    bit acc;
    y = model_y(x);
`ifdef AUDIO_FFT_FRAMER_PREEMPH_EN
    m_xprev = int'($signed(x));
`endif
    acc = 1'b0;
    if (m_active) begin
      acc = 1'b1;
    end else if (enable_in) begin
      acc = 1'b1;
      m_active = 1'b1;
    end
    if (acc) begin
      if (do_push) push_word(y);
      m_in_cnt++;
      if (m_in_cnt == FRAME_LEN) begin
        m_in_cnt = 0;
        if (!enable_in) m_active = 1'b0;
      end
    end
    last_y = y;
    audio_data_in  = x;
    audio_valid_in = 1'b1;
    @(posedge clk_in); #1;
    audio_valid_in = 1'b0;
    for (int g = 1; g < gap; g++) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic reset_dut();
    rst_in = 1'b1;
    audio_valid_in = 1'b0;
    exp_q.delete();
    out_idx = 0;
    m_active = 1'b0;
    m_in_cnt = 0;
`ifdef AUDIO_FFT_FRAMER_PREEMPH_EN
    m_xprev = 0;
`endif
    repeat (2) begin
      @(posedge clk_in); #1;
    end
    rst_in = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    @(negedge clk_in);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    check({tag, "_tdata"}, m_axis_tdata, 32'd0);
    check({tag, "_overflow"}, 32'(overflow_out), 32'd0);
    check({tag, "_drops"}, 32'(drop_count_out), 32'd0);
    check({tag, "_frames"}, 32'(frame_count_out), 32'd0);
  endtask

  // Wait (bounded) for every expected word, then confirm nothing else is offered.
  task automatic wait_drain(input string name, input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0) && (t < budget)) begin
      @(posedge clk_in);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d words outstanding after %0d cycles", name, exp_q.size(), budget);
    end
    repeat (6) @(posedge clk_in);
    @(negedge clk_in);
    check({name, "_idle_tvalid"}, 32'(m_axis_tvalid), 32'd0);
  endtask

  // Ready driver.
  initial begin
    forever begin
      @(posedge clk_in); #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        2:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = ($urandom_range(3, 0) != 0);
      endcase
    end
  end

  // Monitor: compares every handshaken word with the queue head and checks AXI hold.
  initial begin
    exp_t        e;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("axi_hold_tvalid", 32'(m_axis_tvalid), 32'd1);
          check("axi_hold_tdata", m_axis_tdata, prev_data);
          check("axi_hold_tlast", 32'(m_axis_tlast), 32'(prev_last));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_word: got 0x%0h with empty expectation queue (t=%0t)",
                     m_axis_tdata, $time);
          end else begin
            e = exp_q.pop_front();
            check("word_data", m_axis_tdata, {e.data, 16'h0000});
            check("word_last", 32'(m_axis_tlast), 32'(e.last));
          end
          words_seen++;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] k;
    logic [15:0] ys [40];

    // Reset state.
    reset_dut();
    check_zero_outputs("reset");

    // Constant frame, always ready, with first-word latency check.
    rdy_mode = 1;
    enable_in = 1'b1;
    k = 16'($urandom);
    strobe(k, 1'b1, 1);
    @(negedge clk_in);
    check("latency_n1_tvalid", 32'(m_axis_tvalid), 32'd0);
    @(negedge clk_in);
    check("latency_n2_tvalid", 32'(m_axis_tvalid), 32'd1);
    @(posedge clk_in); #1;
    for (int i = 1; i < FRAME_LEN; i++) strobe(k, 1'b1, 1);
    wait_drain("const", 200);
    check("const_frames", 32'(frame_count_out), 32'd1);
    check("const_drops", 32'(drop_count_out), 32'd0);

    // Ramp over two frames with ready toggling every cycle; framing stops after frame 2.
    reset_dut();
    rdy_mode = 2;
    enable_in = 1'b1;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      if (i == 2 * FRAME_LEN - 1) enable_in = 1'b0;
      strobe(16'(i), 1'b1, int'($urandom_range(4, 2)));
    end
    wait_drain("ramp", 200);
    check("ramp_frames", 32'(frame_count_out), 32'd2);
    check("ramp_overflow", 32'(overflow_out), 32'd0);
    check("ramp_drops", 32'(drop_count_out), 32'd0);

    // Overflow: 40 back-to-back strobes with ready low. 16 fit the FIFO, the newest
    // survives in the input stage, and every older stalled sample becomes a zero word.
    reset_dut();
    rdy_mode = 0;
    repeat (3) @(posedge clk_in);
    #1;
    enable_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      strobe(16'($urandom), 1'b0, 1);
      ys[i] = last_y;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) push_word(ys[i]);
    for (int i = 0; i < 40 - FIFO_DEPTH - 1; i++) push_word(16'h0000);
    push_word(ys[39]);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("ovf_flag", 32'(overflow_out), 32'd1);
    check("ovf_drops", 32'(drop_count_out), 32'd23);
    check("ovf_stalled_tvalid", 32'(m_axis_tvalid), 32'd1);
    rdy_mode = 1;
    repeat (60) @(posedge clk_in);
    #1;
    for (int i = 40; i < FRAME_LEN; i++) strobe(16'($urandom), 1'b1, 2);
    wait_drain("ovf", 300);
    check("ovf_frames", 32'(frame_count_out), 32'd1);
    check("ovf_drops_final", 32'(drop_count_out), 32'd23);

    // enable_in drops during frame 0: frame completes, later samples produce nothing.
    reset_dut();
    rdy_mode = 3;
    enable_in = 1'b1;
    for (int i = 0; i < FRAME_LEN + 50; i++) begin
      if (i == 100) enable_in = 1'b0;
      strobe(16'($urandom), 1'b1, int'($urandom_range(4, 2)));
    end
    wait_drain("disable", 300);
    check("disable_frames", 32'(frame_count_out), 32'd1);
    check("disable_drops", 32'(drop_count_out), 32'd0);

    // Reset in the middle of a frame, then a fresh frame from word 0.
    reset_dut();
    rdy_mode = 1;
    enable_in = 1'b1;
    words_seen = 0;
    for (int i = 0; (i < 2 * FRAME_LEN) && (words_seen < 200); i++) begin
      strobe(16'($urandom), 1'b1, 1);
    end
    check("midreset_reached_200", 32'(words_seen >= 200), 32'd1);
    rdy_mode = 0;
    repeat (2) begin
      @(posedge clk_in); #1;
    end
    reset_dut();
    check_zero_outputs("midreset");
    rdy_mode = 1;
    for (int i = 0; i < FRAME_LEN; i++) strobe(16'($urandom), 1'b1, 1);
    wait_drain("postreset", 200);
    check("postreset_frames", 32'(frame_count_out), 32'd1);

`ifdef AUDIO_FFT_FRAMER_PREEMPH_EN
    // Pre-emphasis saturation and settling on a constant input.
    reset_dut();
    rdy_mode = 1;
    enable_in = 1'b1;
    strobe(16'h7FFF, 1'b1, 2);
    strobe(16'h8000, 1'b1, 2);
    check("preemph_sat_model", 32'(last_y), 32'h8000);
    for (int i = 0; i < 6; i++) strobe(16'd1024, 1'b1, 2);
    check("preemph_settle_model", 32'(last_y), 32'd32);
    wait_drain("preemph", 100);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
